seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit 7-segment display. It holds a double-buffered 4-digit frame (hex nibbles, decimal points, per-digit LE and blink enables) and scans it one digit at a time. Each cycle it presents the selected digit to a single downstream Hex2Seg decoder, which computes `LE & flash`, and it drives the shared active-low anode lines. Frame updates commit only at frame boundaries, so the display never tears.

---
 rtl/seg_pkg.sv | 16 +
 rtl/scan_tick_gen.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan path.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [3:0] hex;
    logic       point;
    logic       le;
    logic       blink;
  } digit_rec_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Modulo-N free-running counter; tick marks the last count of each period.
module scan_tick_gen #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans a double-buffered 4-digit frame onto one shared decoder and anode bus.
// New frames commit only at frame boundaries so the display never tears.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hex_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  le_in,
  input  logic [3:0]  blink_in,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic        flash,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  digit_idx_t       idx;
  logic             boundary;
  logic [BW-1:0]    bcnt;
  logic             phase;
  logic             pending_r;

  digit_rec_t stage_r [NUM_DIGITS];
  digit_rec_t act_r   [NUM_DIGITS];

  logic [3:0] hex_p1;
  logic       point_p1;
  logic       le_p1;
  logic       flash_p1;
  logic [3:0] an_p1;
  logic       fd_p1;

  scan_tick_gen #(.N(SCAN_DIV), .CW(CNT_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= idx + digit_idx_t'(1);
  end

  // A load on the boundary cycle still commits the old staging; the new frame waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stage_r[i] <= '0;
        act_r[i]   <= '0;
      end
      pending_r <= 1'b0;
    end else begin
      if (boundary && pending_r) begin
        for (int i = 0; i < NUM_DIGITS; i++) act_r[i] <= stage_r[i];
      end
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          stage_r[i] <= '{hex: hex_in[4*i +: 4], point: point_in[i],
                          le: le_in[i], blink: blink_in[i]};
        end
      end
      pending_r <= load | (pending_r & ~boundary);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary) begin
      if (bcnt == BLAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  // Output stage: one register between the scan state and the decoder/anodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_p1   <= '0;
      point_p1 <= 1'b0;
      le_p1    <= 1'b0;
      flash_p1 <= 1'b1;
      an_p1    <= AN_OFF;
      fd_p1    <= 1'b0;
    end else begin
      hex_p1   <= act_r[idx].hex;
      point_p1 <= act_r[idx].point;
      le_p1    <= act_r[idx].le;
      flash_p1 <= act_r[idx].blink ? ~phase : 1'b1;
      an_p1    <= (cnt == '0) ? AN_OFF : ~(4'b0001 << idx);
      fd_p1    <= boundary;
    end
  end

  assign hex        = hex_p1;
  assign point      = point_p1;
  assign le         = le_p1;
  assign flash      = flash_p1;
  assign an         = an_p1;
  assign frame_done = fd_p1;
  assign pending    = pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a frame-level model.
module tb_seg_scan_ctrl;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  point_in = '0, le_in = '0, blink_in = '0;
  logic [3:0]  hex, an;
  logic        point, le, flash, pending, frame_done;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  typedef struct {
    int          k;
    logic [15:0] h;
    logic [3:0]  pt;
    logic [3:0]  le;
    logic [3:0]  bl;
  } ld_t;
  ld_t lq[$];

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .point_in(point_in),
    .le_in(le_in), .blink_in(blink_in), .hex(hex), .point(point), .le(le),
    .flash(flash), .an(an), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Index of the latest load captured strictly before edge lim, or -1.
  function automatic int last_load_before(input int lim);
    for (int i = lq.size() - 1; i >= 0; i--)
      if (lq[i].k < lim) return i;
    return -1;
  endfunction

  task automatic check_model();
    int p, c, d, f, li, ph;
    logic [3:0] one, e_an, e_bl;
    logic [3:0] e_hex;
    logic e_pt, e_le, e_fl, e_pend, e_fd;
    p = k - 1;
    c = p % SD;
    d = (p / SD) % 4;
    f = p / FRAME;
    ph = (f / BF) % 2;
    li = last_load_before(FRAME * f);
    e_hex = '0; e_pt = 0; e_le = 0; e_bl = '0;
    if (f > 0 && li >= 0) begin
      e_hex = lq[li].h[4*d +: 4];
      e_pt  = lq[li].pt[d];
      e_le  = lq[li].le[d];
      e_bl  = lq[li].bl;
    end
    one = 4'b0001;
    e_an = (c == 0) ? 4'hF : ~(one << d);
    e_fl = e_bl[d] ? (ph == 0) : 1'b1;
    e_fd = (p % FRAME) == FRAME - 1;
    e_pend = (lq.size() > 0) && (lq[lq.size()-1].k >= (k / FRAME) * FRAME);
    check("an", 16'(an), 16'(e_an));
    check("hex", 16'(hex), 16'(e_hex));
    check("point", 16'(point), 16'(e_pt));
    check("le", 16'(le), 16'(e_le));
    check("flash", 16'(flash), 16'(e_fl));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    check("pending", 16'(pending), 16'(e_pend));
  endtask

  task automatic check_reset_vals();
    check("rst_an", 16'(an), 16'hF);
    check("rst_hex", 16'(hex), 16'h0);
    check("rst_point", 16'(point), 16'h0);
    check("rst_le", 16'(le), 16'h0);
    check("rst_flash", 16'(flash), 16'h1);
    check("rst_fd", 16'(frame_done), 16'h0);
    check("rst_pending", 16'(pending), 16'h0);
  endtask

  task automatic cyc(input logic ld, input logic [15:0] h, input logic [3:0] pt,
                     input logic [3:0] l, input logic [3:0] bl);
    load = ld; hex_in = h; point_in = pt; le_in = l; blink_in = bl;
    @(posedge clk);
    k++;
    if (ld) lq.push_back('{k: k, h: h, pt: pt, le: l, bl: bl});
    #1;
    load = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    // Reset held: outputs at reset values.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_vals();
    end
    rst = 1'b0;
    k = 0;
    lq.delete();

    // Anode scan pattern with blank data.
    idle(20);

    // Mid-frame load of 4321 / points 0101.
    while (k % FRAME != 6) idle(1);
    cyc(1'b1, 16'h4321, 4'b0101, 4'hF, 4'h0);
    idle(40);

    // Two loads in one frame: only the second is shown.
    while (k % FRAME != 3) idle(1);
    cyc(1'b1, 16'hAAAA, 4'b1111, 4'h0, 4'h0);
    idle(2);
    cyc(1'b1, 16'hBCDE, 4'b0011, 4'hF, 4'h0);
    idle(20);

    // Load captured exactly on the boundary edge.
    cyc(1'b1, 16'h5678, 4'b1000, 4'hF, 4'h0);
    while (k % FRAME != FRAME - 1) idle(1);
    cyc(1'b1, 16'h9ABC, 4'b0001, 4'h5, 4'h0);
    idle(40);

    // Blink on digit 1 only.
    cyc(1'b1, 16'h1234, 4'b0000, 4'hF, 4'b0010);
    idle(6 * FRAME);

    // Randomized loads.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    // Reset mid-slot with a staged frame pending.
    while (k % SD != 1) idle(1);
    cyc(1'b1, 16'hFEDC, 4'hF, 4'hF, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    rst = 1'b0;
    k = 0;
    lq.delete();
    idle(3 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
